// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Main controller FSM for the multicycle MIPS datapath. Advances one
//   microstep per clock and drives the datapath mux selects, write enables
//   and ALU control from the current state. Also counts retired
//   instructions and strobes an unsupported opcode.
//
//   Optional feature: define MC_BNE_EN to add bne (op 000101) through the
//   BNEEX state. Without it, op 000101 is treated as illegal.
//
// Parameters
//   INSTRET_W   width of the retired-instruction counter (wraps)
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   op, funct   instruction fields from the instruction register
//   zero        ALU zero flag of the current cycle
//   iord, memwrite, irwrite, regdst, memtoreg, regwrite,
//   alusrca, alusrcb, pcsrc, alucontrol, pcen
//               datapath controls
//   illegal     one-cycle strobe in DECODE for an unsupported opcode
//   state       current state encoding (debug)
//   instret     retired-instruction count
//
// state   | meaning
// FETCH   | read instruction at PC, PC <= PC + 4
// DECODE  | read registers, branch target into ALUOut, dispatch on op
// MEMADR  | effective address for lw/sw
// MEMRD   | data memory read
// MEMWB   | load result written to rt
// MEMWR   | data memory write
// RTYPEEX | R-type ALU operation
// RTYPEWB | R-type result written to rd
// BEQEX   | compare and conditionally branch (beq)
// ADDIEX  | rs + immediate
// ADDIWB  | addi result written to rt
// JEX     | jump
// BNEEX   | compare and conditionally branch (bne, optional)

module mips_multicycle_ctrl #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    output logic                 iord,
    output logic                 memwrite,
    output logic                 irwrite,
    output logic                 regdst,
    output logic                 memtoreg,
    output logic                 regwrite,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic [1:0]           pcsrc,
    output logic [2:0]           alucontrol,
    output logic                 pcen,
    output logic                 illegal,
    output logic [3:0]           state,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_BNEEX   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state_q;
    state_t state_d;
    state_t dec_state;
    logic   pcwrite;
    logic   branch_eq;
    logic   branch_ne;
    logic   retire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            instret <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instret <= instret + INSTRET_W'(1);
            end
        end
    end

    assign state = state_q;

    // Next state and retire are taken from the registered state.
    always_comb begin
        state_d = S_FETCH;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
`ifdef MC_BNE_EN
                    OP_BNE:       state_d = S_BNEEX;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_MEMWB, S_MEMWR, S_RTYPEWB, S_BEQEX, S_ADDIWB, S_JEX: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
`ifdef MC_BNE_EN
            S_BNEEX: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
`endif
            default:   state_d = S_FETCH;
        endcase
    end

    // Outputs decode FETCH while reset is held so the datapath sees a
    // quiescent fetch; the write enables are additionally forced low.
    assign dec_state = rst ? S_FETCH : state_q;

    always_comb begin
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b000;
        pcwrite    = 1'b0;
        branch_eq  = 1'b0;
        branch_ne  = 1'b0;
        illegal    = 1'b0;
        case (dec_state)
            S_FETCH: begin
                irwrite    = 1'b1;
                alusrcb    = 2'b01;
                alucontrol = ALU_ADD;
                pcwrite    = 1'b1;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = ALU_ADD;
                case (op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal = 1'b0;
`ifdef MC_BNE_EN
                    OP_BNE:  illegal = 1'b0;
`endif
                    default: illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                case (funct)
                    6'b100010: alucontrol = ALU_SUB;
                    6'b100100: alucontrol = ALU_AND;
                    6'b100101: alucontrol = ALU_OR;
                    6'b101010: alucontrol = ALU_SLT;
                    default:   alucontrol = ALU_ADD;
                endcase
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                branch_eq  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
`ifdef MC_BNE_EN
            S_BNEEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                branch_ne  = 1'b1;
            end
`endif
            default: ;
        endcase

        pcen = pcwrite | (branch_eq & zero) | (branch_ne & ~zero);

        if (rst) begin
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            pcen     = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl. The stimulus process drives one
// cycle at a time and queues the expected state, control word and retired
// count; a negedge monitor pops and compares each cycle.

module tb_mips_multicycle_ctrl;

    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    op;
    logic [5:0]    funct;
    logic          zero;
    logic          iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0]    alusrcb, pcsrc;
    logic [2:0]    alucontrol;
    logic          pcen, illegal;
    logic [3:0]    state;
    logic [IW-1:0] instret;

    mips_multicycle_ctrl #(.INSTRET_W(IW)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .pcen(pcen), .illegal(illegal), .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    st;
        logic [15:0]   ctrl;
        logic [IW-1:0] ret;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic [IW-1:0] exp_ret = '0;

    // Expected controls per state, written from the controller's state table.
    // Packing: {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,
    //           alusrcb,pcsrc,alucontrol,pcen,illegal}
    function automatic logic [15:0] ctrl_of(input int st, input logic [5:0] fn,
                                            input logic z, input logic r, input logic ill);
        logic io, mw, irw, rd, m2r, rw, asa, pe;
        logic [1:0] asb, pcs;
        logic [2:0] alu;
        io = 0; mw = 0; irw = 0; rd = 0; m2r = 0; rw = 0; asa = 0; pe = 0;
        asb = 2'b00; pcs = 2'b00; alu = 3'b000;
        case (r ? 0 : st)
            0:  begin irw = 1; asb = 2'b01; alu = 3'b010; pe = 1; end
            1:  begin asb = 2'b11; alu = 3'b010; end
            2:  begin asa = 1; asb = 2'b10; alu = 3'b010; end
            3:  io = 1;
            4:  begin m2r = 1; rw = 1; end
            5:  begin io = 1; mw = 1; end
            6:  begin
                    asa = 1;
                    case (fn)
                        6'b100000: alu = 3'b010;
                        6'b100010: alu = 3'b110;
                        6'b100100: alu = 3'b000;
                        6'b100101: alu = 3'b001;
                        6'b101010: alu = 3'b111;
                        default:   alu = 3'b010;
                    endcase
                end
            7:  begin rd = 1; rw = 1; end
            8:  begin asa = 1; alu = 3'b110; pcs = 2'b01; pe = z; end
            9:  begin asa = 1; asb = 2'b10; alu = 3'b010; end
            10: rw = 1;
            11: begin pcs = 2'b10; pe = 1; end
            12: begin asa = 1; alu = 3'b110; pcs = 2'b01; pe = ~z; end
            default: ;
        endcase
        if (r) begin
            irw = 0;
            pe  = 0;
        end
        return {io, mw, irw, rd, m2r, rw, asa, asb, pcs, alu, pe, ill & ~r};
    endfunction

    task automatic step(input logic r, input logic [5:0] o, input logic [5:0] f,
                        input logic z, input int st, input logic ill, input logic ret);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; op = o; funct = f; zero = z;
        e.st   = 4'(st);
        e.ctrl = ctrl_of(st, f, z, r, ill);
        e.ret  = exp_ret;
        sb.push_back(e);
        if (r) exp_ret = '0;
        else if (ret) exp_ret = exp_ret + IW'(1);
    endtask

    // seq lists the states of one instruction from FETCH to its final state.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int len, input int seq[6], input logic ill);
        for (int i = 0; i < len; i++) begin
            step(1'b0, o, f, z, seq[i], ill && (seq[i] == 1), !ill && (i == len - 1));
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [15:0] act;
            e = sb.pop_front();
            act = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                   alusrcb, pcsrc, alucontrol, pcen, illegal};
            n_cmp++;
            if (state !== e.st) begin
                n_err++;
                $display("FAIL state @%0t: got %0d expected %0d", $time, state, e.st);
            end
            n_cmp++;
            if (act !== e.ctrl) begin
                n_err++;
                $display("FAIL ctrl @%0t state %0d: got %b expected %b", $time, state, act, e.ctrl);
            end
            n_cmp++;
            if (instret !== e.ret) begin
                n_err++;
                $display("FAIL instret @%0t: got %0d expected %0d", $time, instret, e.ret);
            end
        end
    end

    initial begin
        rst = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;
        @(posedge clk);

        repeat (3) step(1'b1, 6'd0, 6'd0, 1'b0, 0, 1'b0, 1'b0);

        run_instr(6'b100011, 6'd0, 1'b0, 5, '{0, 1, 2, 3, 4, 0}, 1'b0);          // lw
        run_instr(6'b000000, 6'b101010, 1'b0, 4, '{0, 1, 6, 7, 0, 0}, 1'b0);     // slt
        run_instr(6'b000000, 6'b100000, 1'b1, 4, '{0, 1, 6, 7, 0, 0}, 1'b0);     // add
        run_instr(6'b000000, 6'b100010, 1'b0, 4, '{0, 1, 6, 7, 0, 0}, 1'b0);     // sub
        run_instr(6'b000000, 6'b100100, 1'b0, 4, '{0, 1, 6, 7, 0, 0}, 1'b0);     // and
        run_instr(6'b000000, 6'b100101, 1'b0, 4, '{0, 1, 6, 7, 0, 0}, 1'b0);     // or
        run_instr(6'b000000, 6'b111111, 1'b0, 4, '{0, 1, 6, 7, 0, 0}, 1'b0);     // unknown funct
        run_instr(6'b000100, 6'd0, 1'b1, 3, '{0, 1, 8, 0, 0, 0}, 1'b0);          // beq taken
        run_instr(6'b000100, 6'd0, 1'b0, 3, '{0, 1, 8, 0, 0, 0}, 1'b0);          // beq not taken
        run_instr(6'b111111, 6'd0, 1'b0, 2, '{0, 1, 0, 0, 0, 0}, 1'b1);          // illegal
        run_instr(6'b101011, 6'd0, 1'b0, 4, '{0, 1, 2, 5, 0, 0}, 1'b0);          // sw
        run_instr(6'b001000, 6'd0, 1'b0, 4, '{0, 1, 9, 10, 0, 0}, 1'b0);         // addi
        run_instr(6'b000010, 6'd0, 1'b0, 3, '{0, 1, 11, 0, 0, 0}, 1'b0);         // j
`ifdef MC_BNE_EN
        run_instr(6'b000101, 6'd0, 1'b0, 3, '{0, 1, 12, 0, 0, 0}, 1'b0);         // bne taken
        run_instr(6'b000101, 6'd0, 1'b1, 3, '{0, 1, 12, 0, 0, 0}, 1'b0);         // bne not taken
`else
        run_instr(6'b000101, 6'd0, 1'b0, 2, '{0, 1, 0, 0, 0, 0}, 1'b1);          // bne illegal
`endif

        // sw abandoned by a reset raised while in MEMADR
        step(1'b0, 6'b101011, 6'd0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 6'b101011, 6'd0, 1'b0, 1, 1'b0, 1'b0);
        step(1'b1, 6'b101011, 6'd0, 1'b0, 2, 1'b0, 1'b0);
        step(1'b0, 6'b101011, 6'd0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 6'b101011, 6'd0, 1'b0, 1, 1'b0, 1'b0);
        step(1'b0, 6'b101011, 6'd0, 1'b0, 2, 1'b0, 1'b0);
        step(1'b0, 6'b101011, 6'd0, 1'b0, 5, 1'b0, 1'b1);

        // 16 more retires wrap the narrow counter back to 1
        for (int k = 0; k < 16; k++) begin
            run_instr(6'b000010, 6'd0, 1'b0, 3, '{0, 1, 11, 0, 0, 0}, 1'b0);
        end
        step(1'b0, 6'd0, 6'd0, 1'b0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
